// File: rtl/hit_judge_pkg.sv
// Shared types and defaults for the whack-a-mole hit judge.
// Event encoding is also usable by benches observing the judge.
package hit_judge_pkg;

  localparam int unsigned N_HOLES_DEF        = 8;
  localparam int unsigned LOCKOUT_CYCLES_DEF = 12_500_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_MISS = 2'd1,
    EVT_HIT  = 2'd2,
    EVT_FULL = 2'd3
  } evt_e;

endpackage

// File: rtl/lowest_set_onehot.sv
// Combinational extractor: isolates the lowest set bit of a vector as a one-hot mask.
module lowest_set_onehot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [WIDTH-1:0] onehot_c_o
);

  // Two's-complement trick: x & -x keeps only the least significant one.
  assign onehot_c_o = vec_i & (~vec_i + WIDTH'(1));

endmodule

// File: rtl/hit_judge.sv
// Judges debounced button presses against the mole board and emits scoring pulses.
// Define WRONG_HIT_LOCKOUT_EN to enable the post-wrong-hit input lockout.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int unsigned N_HOLES        = N_HOLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               game_active,
  input  logic [N_HOLES-1:0] buttons,
  input  logic [N_HOLES-1:0] mole_up,
  input  logic [N_HOLES-1:0] mole_expired,
  output logic               miss,
  output logic               non_full_clear_hit,
  output logic               full_clear_hit,
  output logic [N_HOLES-1:0] whack_mask,
  output logic               lockout
);

  if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
    $error("LOCKOUT_CYCLES must be at least 1");
  end

  state_e             state_q, state_d;
  logic [N_HOLES-1:0] pending_q, pending_d;
  logic [N_HOLES-1:0] btn_prev_q;
  logic [N_HOLES-1:0] whack_q, whack_d;
  logic [N_HOLES-1:0] new_press, served, eff_up;
  logic               miss_q, nfch_q, fch_q;
  evt_e               evt_d;
  logic               judge_en, expiry_en;
  logic               hit_ok, wrong_hit, expired;
  logic               lock_done;

  lowest_set_onehot #(.WIDTH(N_HOLES)) u_served (
    .vec_i      (pending_q),
    .onehot_c_o (served)
  );

  // The spawner lowers a whacked mole one cycle late; hide it from the judge meanwhile.
  assign new_press = buttons & ~btn_prev_q;
  assign eff_up    = mole_up & ~whack_q;
  assign judge_en  = game_active && (state_q == ARMED);
  assign expiry_en = game_active && (state_q == ARMED || state_q == LOCKOUT);
  assign hit_ok    = |(served & eff_up);
  assign wrong_hit = judge_en && (|served) && !hit_ok;
  assign expired   = |(mole_expired & mole_up);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!game_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED: begin
`ifdef WRONG_HIT_LOCKOUT_EN
          if (wrong_hit) state_d = LOCKOUT;
`endif
        end
        LOCKOUT: if (lock_done) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Judgement and queue update; expiry overrides any hit pulse but keeps the whack.
  always_comb begin
    evt_d     = EVT_NONE;
    whack_d   = '0;
    pending_d = '0;
    if (judge_en) begin
      pending_d = (pending_q & ~served) | new_press;
      if (wrong_hit) begin
        evt_d     = EVT_MISS;
        pending_d = '0;
      end else if (hit_ok) begin
        whack_d = served;
        evt_d   = ((eff_up & ~served) == '0) ? EVT_FULL : EVT_HIT;
      end
    end
    if (expiry_en && expired) begin
      evt_d = EVT_MISS;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q  <= '0;
      btn_prev_q <= '0;
      whack_q    <= '0;
      miss_q     <= 1'b0;
      nfch_q     <= 1'b0;
      fch_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      btn_prev_q <= buttons;
      whack_q    <= whack_d;
      miss_q     <= (evt_d == EVT_MISS);
      nfch_q     <= (evt_d == EVT_HIT);
      fch_q      <= (evt_d == EVT_FULL);
    end
  end

  assign miss               = miss_q;
  assign non_full_clear_hit = nfch_q;
  assign full_clear_hit     = fch_q;
  assign whack_mask         = whack_q;

`ifdef WRONG_HIT_LOCKOUT_EN
  localparam int unsigned CNT_W = $clog2(LOCKOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lockout_q;

  // Counter is zero outside LOCKOUT, so each entry restarts the count.
  assign lock_done = (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (game_active && state_q == LOCKOUT && !lock_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      lockout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lockout_q <= (state_d == LOCKOUT);
    end
  end

  assign lockout = lockout_q;
`else
  assign lock_done = 1'b1;
  assign lockout   = 1'b0;
`endif

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: directed scenarios with literal expectations
// followed by randomized stimulus compared every cycle against a behavioural model.
module tb_hit_judge;

  localparam int NH = 8;
  localparam int LC = 4;
`ifdef WRONG_HIT_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          game_active;
  logic [NH-1:0] buttons;
  logic [NH-1:0] mole_up;
  logic [NH-1:0] mole_expired;
  logic          miss;
  logic          non_full_clear_hit;
  logic          full_clear_hit;
  logic [NH-1:0] whack_mask;
  logic          lockout;

  int errors = 0;
  int checks = 0;

  hit_judge #(.N_HOLES(NH), .LOCKOUT_CYCLES(LC)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .game_active        (game_active),
    .buttons            (buttons),
    .mole_up            (mole_up),
    .mole_expired       (mole_expired),
    .miss               (miss),
    .non_full_clear_hit (non_full_clear_hit),
    .full_clear_hit     (full_clear_hit),
    .whack_mask         (whack_mask),
    .lockout            (lockout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 armed, 2 locked out; pending is a set of holes.
  int            m_mode = 0;
  int            m_left = 0;
  logic [NH-1:0] m_pend = '0;
  logic [NH-1:0] m_prev = '0;
  logic [NH-1:0] m_lastw = '0;
  logic          e_miss = 1'b0, e_nf = 1'b0, e_fc = 1'b0, e_lock = 1'b0;
  logic [NH-1:0] e_wm = '0;

  task automatic model_step();
    logic [NH-1:0] np;
    logic [NH-1:0] wm;
    logic          nm, nf, fc;
    int            s, others;
    nm = 1'b0; nf = 1'b0; fc = 1'b0; wm = '0;
    if (!reset_n) begin
      m_mode = 0; m_left = 0; m_pend = '0; m_prev = '0; m_lastw = '0;
    end else begin
      np     = buttons & ~m_prev;
      m_prev = buttons;
      if (!game_active) begin
        m_mode = 0; m_pend = '0; m_left = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        if (m_mode == 1) begin
          s = -1;
          for (int i = NH - 1; i >= 0; i--) if (m_pend[i]) s = i;
          if (s < 0) begin
            m_pend = m_pend | np;
          end else if (mole_up[s] && !m_lastw[s]) begin
            wm[s] = 1'b1;
            others = 0;
            for (int i = 0; i < NH; i++) if (i != s && mole_up[i] && !m_lastw[i]) others++;
            if (others == 0) fc = 1'b1; else nf = 1'b1;
            m_pend[s] = 1'b0;
            m_pend = m_pend | np;
          end else begin
            nm = 1'b1;
            m_pend = '0;
            if (LOCK_EN) begin
              m_mode = 2; m_left = LC;
            end
          end
        end else begin
          m_left--;
          if (m_left == 0) m_mode = 1;
        end
        if ((mole_expired & mole_up) != '0) begin
          nm = 1'b1; nf = 1'b0; fc = 1'b0;
        end
      end
      m_lastw = wm;
    end
    e_miss = nm; e_nf = nf; e_fc = fc; e_wm = wm;
    e_lock = (m_mode == 2);
  endtask

  // Every cycle: advance the model at the edge, compare once outputs settle.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("model_miss", miss, e_miss);
    chk("model_nfch", non_full_clear_hit, e_nf);
    chk("model_fch", full_clear_hit, e_fc);
    chk("model_whack", whack_mask, e_wm);
    chk("model_lockout", lockout, e_lock);
  end

  task automatic step(input logic [NH-1:0] b, input logic [NH-1:0] u, input logic [NH-1:0] e);
    @(negedge clk);
    buttons = b; mole_up = u; mole_expired = e;
  endtask

  initial begin
    reset_n = 1'b0; game_active = 1'b0;
    buttons = '0; mole_up = '0; mole_expired = '0;
    repeat (2) @(negedge clk);
    chk("reset_miss", miss, 0);
    chk("reset_nfch", non_full_clear_hit, 0);
    chk("reset_fch", full_clear_hit, 0);
    chk("reset_whack", whack_mask, 0);
    chk("reset_lockout", lockout, 0);

    reset_n = 1'b1; game_active = 1'b1;
    step(8'h00, 8'h05, 8'h00);
    step(8'h00, 8'h05, 8'h00);

    // Correct non-final hit.
    step(8'h04, 8'h05, 8'h00);
    step(8'h04, 8'h05, 8'h00);
    @(negedge clk);
    chk("nonfinal_nfch", non_full_clear_hit, 1);
    chk("nonfinal_whack", whack_mask, 8'h04);
    chk("nonfinal_miss", miss, 0);

    // Full clear.
    step(8'h00, 8'h10, 8'h00);
    step(8'h10, 8'h10, 8'h00);
    step(8'h10, 8'h10, 8'h00);
    @(negedge clk);
    chk("full_fch", full_clear_hit, 1);
    chk("full_whack", whack_mask, 8'h10);

    // Two simultaneous presses, second relies on whacked_last masking.
    step(8'h00, 8'h03, 8'h00);
    step(8'h03, 8'h03, 8'h00);
    step(8'h03, 8'h03, 8'h00);
    @(negedge clk);
    chk("dual1_nfch", non_full_clear_hit, 1);
    chk("dual1_whack", whack_mask, 8'h01);
    @(negedge clk);
    chk("dual2_fch", full_clear_hit, 1);
    chk("dual2_whack", whack_mask, 8'h02);

    // Expiry concurrent with a correct hit.
    step(8'h00, 8'h03, 8'h00);
    step(8'h01, 8'h03, 8'h00);
    step(8'h01, 8'h03, 8'h02);
    @(negedge clk);
    chk("exphit_miss", miss, 1);
    chk("exphit_nfch", non_full_clear_hit, 0);
    chk("exphit_fch", full_clear_hit, 0);
    chk("exphit_whack", whack_mask, 8'h01);
    step(8'h00, 8'h03, 8'h00);
    step(8'h00, 8'h03, 8'h00);

    // Wrong hit, then lockout window.
    step(8'h00, 8'h00, 8'h00);
    step(8'h08, 8'h00, 8'h00);
    step(8'h08, 8'h00, 8'h00);
    @(negedge clk);
    chk("wrong_miss", miss, 1);
    chk("wrong_lockout", lockout, LOCK_EN);
    if (LOCK_EN) begin
      step(8'h20, 8'h20, 8'h00);
      step(8'h20, 8'h20, 8'h00);
      step(8'h00, 8'h20, 8'h00);
      chk("lock_held", lockout, 1);
      step(8'h00, 8'h20, 8'h00);
      chk("lock_released", lockout, 0);
      chk("lock_no_hit", full_clear_hit, 0);
      step(8'h20, 8'h20, 8'h00);
      step(8'h20, 8'h20, 8'h00);
      @(negedge clk);
      chk("after_lock_fch", full_clear_hit, 1);
      chk("after_lock_whack", whack_mask, 8'h20);
    end
    step(8'h00, 8'h00, 8'h00);
    repeat (3) step(8'h00, 8'hff, 8'h00);

    // Game stop with three presses pending; held buttons must stay silent.
    step(8'h07, 8'hff, 8'h00);
    game_active = 1'b0;
    step(8'h07, 8'hff, 8'h00);
    @(negedge clk);
    chk("stop_miss", miss, 0);
    chk("stop_nfch", non_full_clear_hit, 0);
    chk("stop_whack", whack_mask, 0);
    game_active = 1'b1;
    repeat (4) step(8'h07, 8'hff, 8'h00);
    chk("held_nfch", non_full_clear_hit, 0);
    chk("held_whack", whack_mask, 0);
    step(8'h00, 8'hff, 8'h00);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 149) == 0) game_active = ~game_active;
      else if (!game_active && $urandom_range(0, 9) == 0) game_active = 1'b1;
      if ($urandom_range(0, 2) == 0) buttons = buttons ^ NH'(1 << $urandom_range(0, NH - 1));
      if ($urandom_range(0, 2) == 0) buttons = buttons ^ NH'(1 << $urandom_range(0, NH - 1));
      if ($urandom_range(0, 7) == 0) mole_up = NH'($urandom);
      mole_expired = ($urandom_range(0, 11) == 0) ? NH'($urandom) : '0;
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
